result_frame_rx: RTL

- Receiving end of the result-upload link.
- Deserialises the 8N1 UART stream that carries echo results and parses the 9-byte result frame.
- Checks the frame checksum and presents echo_tof / echo_peak with a one-cycle valid pulse.
- Used as the host-side/loopback endpoint, fed from the TBS receive path in bench and bring-up builds. Runs entirely on the 50 MHz system clock.

---
 rtl/result_frame_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/result_frame_rx.sv
// 8N1 UART receiver plus parser for the 9-byte result frame (AA 55 T2 T1 T0 P2 P1 P0 CS).
// A good frame updates echo_tof/echo_peak with a frame_valid pulse; anything discarded pulses frame_err.
module result_frame_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        rs232_rx,
  output logic [19:0] echo_tof,
  output logic [17:0] echo_peak,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT + 1);
  localparam int TO_LIM  = TIMEOUT_BITS * BIT_CNT;
  localparam int TW      = $clog2(TO_LIM + 2);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [TW-1:0] GAP_LIM  = TW'(TO_LIM);

  typedef enum logic [1:0] {E_IDLE, E_START, E_DATA, E_STOP} eng_state_t;
  typedef enum logic [1:0] {P_HUNT1, P_HUNT2, P_PAYLOAD, P_CHECK} par_state_t;

  eng_state_t    e_state, e_next;
  par_state_t    p_state, p_next;

  logic          rx_s1, rx_s2, rx_d;
  logic          fall;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_stb;
  logic          cnt_clr, bit_clr, shift_en, stop_ok, stop_bad;

  logic [2:0]    idx, idx_n;
  logic [7:0]    sum, sum_n;
  logic [7:0]    pl [0:5];
  logic          pl_we;
  logic [TW-1:0] gap_cnt;
  logic          timeout;
  logic          chk_ok, chk_bad;

  // Synchroniser and edge-detect flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rs232_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall = rx_d & ~rx_s2;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      e_state  <= E_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_stb <= 1'b0;
    end else begin
      e_state  <= e_next;
      cnt      <= cnt_clr ? '0 : cnt + 1'b1;
      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en)      shreg <= {rx_s2, shreg[7:1]};
      byte_stb <= stop_ok;
    end
  end

  always_comb begin
    e_next   = e_state;
    cnt_clr  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (e_state)
      E_IDLE: begin
        if (fall) begin
          e_next  = E_START;
          cnt_clr = 1'b1;
        end
      end
      E_START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          if (rx_s2) begin
            e_next = E_IDLE;
          end else begin
            e_next  = E_DATA;
            bit_clr = 1'b1;
          end
        end
      end
      E_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) e_next = E_STOP;
        end
      end
      E_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_clr = 1'b1;
          e_next  = E_IDLE;
          if (rx_s2) stop_ok  = 1'b1;
          else       stop_bad = 1'b1;
        end
      end
      default: e_next = E_IDLE;
    endcase
  end

  // Inter-byte gap: only idle engine cycles count, and only while a frame is in progress.
  assign timeout = (p_state != P_HUNT1) && (e_state == E_IDLE) && !fall && (gap_cnt == GAP_LIM);

  always_comb begin
    p_next  = p_state;
    idx_n   = idx;
    sum_n   = sum;
    pl_we   = 1'b0;
    chk_ok  = 1'b0;
    chk_bad = 1'b0;
    if (stop_bad || timeout) begin
      p_next = P_HUNT1;
    end else if (byte_stb) begin
      case (p_state)
        P_HUNT1: if (shreg == 8'hAA) p_next = P_HUNT2;
        P_HUNT2: begin
          if (shreg == 8'h55) begin
            p_next = P_PAYLOAD;
            idx_n  = 3'd0;
            sum_n  = 8'h00;
          end else if (shreg != 8'hAA) begin
            p_next = P_HUNT1;
          end
        end
        P_PAYLOAD: begin
          pl_we = 1'b1;
          sum_n = sum + shreg;
          if (idx == 3'd5) p_next = P_CHECK;
          else             idx_n  = idx + 3'd1;
        end
        P_CHECK: begin
          p_next = P_HUNT1;
          if (sum == shreg && pl[0][7:4] == 4'h0 && pl[3][7:2] == 6'h00) chk_ok  = 1'b1;
          else                                                            chk_bad = 1'b1;
        end
        default: p_next = P_HUNT1;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= P_HUNT1;
      idx         <= '0;
      sum         <= '0;
      gap_cnt     <= '0;
      echo_tof    <= '0;
      echo_peak   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      for (int i = 0; i < 6; i++) pl[i] <= '0;
    end else begin
      p_state <= p_next;
      idx     <= idx_n;
      sum     <= sum_n;
      if (pl_we) pl[idx] <= shreg;
      if (e_state != E_IDLE || p_state == P_HUNT1) gap_cnt <= '0;
      else if (gap_cnt != GAP_LIM)                 gap_cnt <= gap_cnt + 1'b1;
      frame_valid <= chk_ok;
      frame_err   <= stop_bad | timeout | chk_bad;
      if (chk_ok) begin
        echo_tof  <= {pl[0][3:0], pl[1], pl[2]};
        echo_peak <= {pl[3][1:0], pl[4], pl[5]};
      end
    end
  end

endmodule
